// File: rtl/spi_upcounter_pkg.sv
// Shared widths, the SPI transmitter state encoding and the frame layout
// for the up-counter / SPI display link.
package spi_upcounter_pkg;

    localparam int COUNT_W = 14;
    localparam int FRAME_W = 16;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SHIFT,
        HOLD,
        GUARD
    } spi_state_t;

    function automatic logic [FRAME_W-1:0] pack_frame(input logic [COUNT_W-1:0] count);
        return {2'b00, count};
    endfunction

endpackage

// File: rtl/spi_frame_tx.sv
// Write-only SPI mode-0 transmitter: sends one 16-bit word MSB first,
// followed by a chip-select hold and an inter-frame guard interval.
module spi_frame_tx
    import spi_upcounter_pkg::*;
#(
    parameter int SCLK_DIV = 50
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start_i,
    input  logic [FRAME_W-1:0] data_i,
    output logic               busy_o,
    output spi_state_t         state_o,
    output logic               sclk_o,
    output logic               mosi_o,
    output logic               cs_n_o
);
    // Handshake: start_i is a level request sampled only in IDLE; data_i is
    // captured in the single LOAD cycle (visible on state_o), after which the
    // requester may change it. busy_o stays high from LOAD to the end of GUARD.

    localparam int DW = $clog2(SCLK_DIV);
    localparam logic [DW-1:0] DIV_LAST = DW'(SCLK_DIV - 1);

    spi_state_t         state_q, state_d;
    logic [DW-1:0]      div_q, div_d;
    logic [3:0]         bit_q, bit_d;
    logic [FRAME_W-1:0] shreg_q, shreg_d;
    logic               sclk_q, sclk_d;
    logic               mosi_q, mosi_d;
    logic               cs_n_q, cs_n_d;
    logic               phase_end;
    logic               last_bit;

    assign phase_end = (div_q == DIV_LAST);
    assign last_bit  = (bit_q == 4'd15);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            div_q   <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            sclk_q  <= 1'b0;
            mosi_q  <= 1'b0;
            cs_n_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            sclk_q  <= sclk_d;
            mosi_q  <= mosi_d;
            cs_n_q  <= cs_n_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_i) state_d = LOAD;
            LOAD:    state_d = SHIFT;
            SHIFT:   if (phase_end && sclk_q && last_bit) state_d = HOLD;
            HOLD:    if (phase_end) state_d = GUARD;
            GUARD:   if (phase_end) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Pin registers update together; mosi only moves on the edge that drops sclk.
    always_comb begin
        div_d   = '0;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        sclk_d  = sclk_q;
        mosi_d  = mosi_q;
        cs_n_d  = cs_n_q;
        case (state_q)
            LOAD: begin
                shreg_d = data_i;
                bit_d   = '0;
                cs_n_d  = 1'b0;
                sclk_d  = 1'b0;
                mosi_d  = data_i[FRAME_W-1];
            end
            SHIFT: begin
                div_d = phase_end ? '0 : div_q + 1'b1;
                if (phase_end) begin
                    if (!sclk_q) begin
                        sclk_d = 1'b1;
                    end else begin
                        sclk_d = 1'b0;
                        if (!last_bit) begin
                            bit_d   = bit_q + 1'b1;
                            shreg_d = {shreg_q[FRAME_W-2:0], 1'b0};
                            mosi_d  = shreg_q[FRAME_W-2];
                        end
                    end
                end
            end
            HOLD: begin
                div_d = phase_end ? '0 : div_q + 1'b1;
                if (phase_end) begin
                    cs_n_d = 1'b1;
                    mosi_d = 1'b0;
                end
            end
            GUARD: begin
                div_d = phase_end ? '0 : div_q + 1'b1;
            end
            default: begin
                div_d = '0;
            end
        endcase
    end

    assign busy_o  = (state_q != IDLE);
    assign state_o = state_q;
    assign sclk_o  = sclk_q;
    assign mosi_o  = mosi_q;
    assign cs_n_o  = cs_n_q;

endmodule

// File: rtl/upcounter_spi_tx.sv
// Run/stop decimal-range up-counter that pushes every new value to an SPI
// display as a 16-bit frame; changes during a frame coalesce into one follow-up.
module upcounter_spi_tx
    import spi_upcounter_pkg::*;
#(
    parameter int TICK_DIV  = 10_000_000,
    parameter int SCLK_DIV  = 50,
    parameter int COUNT_MAX = 9999
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               i_btn_runstop,
    input  logic               i_btn_clear,
    output logic [COUNT_W-1:0] o_count,
    output logic               o_running,
    output logic               o_busy,
    output logic               sclk,
    output logic               mosi,
    output logic               cs_n
);
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0]      PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [COUNT_W-1:0] COUNT_LAST = COUNT_W'(COUNT_MAX);

    logic [COUNT_W-1:0] count_q, count_d;
    logic [PW-1:0]      presc_q, presc_d;
    logic               running_q, running_d;
    logic               pending_q, pending_d;
    logic               tick;
    logic               snap;
    spi_state_t         tx_state;

    assign tick = running_q && (presc_q == PRESC_LAST);
    assign snap = (tx_state == LOAD);

    always_comb begin
        running_d = running_q ^ i_btn_runstop;

        presc_d = presc_q + 1'b1;
        if (i_btn_clear || !running_q || tick) presc_d = '0;

        count_d = count_q;
        if (i_btn_clear)  count_d = '0;
        else if (tick)    count_d = (count_q == COUNT_LAST) ? '0 : count_q + 1'b1;

        // A fresh change in the snapshot cycle must survive for the next frame.
        pending_d = pending_q;
        if (i_btn_clear || tick) pending_d = 1'b1;
        else if (snap)           pending_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q   <= '0;
            presc_q   <= '0;
            running_q <= 1'b0;
            pending_q <= 1'b0;
        end else begin
            count_q   <= count_d;
            presc_q   <= presc_d;
            running_q <= running_d;
            pending_q <= pending_d;
        end
    end

    spi_frame_tx #(
        .SCLK_DIV(SCLK_DIV)
    ) u_tx (
        .clk     (clk),
        .reset   (reset),
        .start_i (pending_q),
        .data_i  (pack_frame(count_q)),
        .busy_o  (o_busy),
        .state_o (tx_state),
        .sclk_o  (sclk),
        .mosi_o  (mosi),
        .cs_n_o  (cs_n)
    );

    assign o_count   = count_q;
    assign o_running = running_q;

endmodule
